// File: rtl/test_input_streamer.sv
// Single-channel strided memory reader: issues OBI-style word reads, buffers the
// responses in a small FIFO and presents them as a valid/ready stream with last/done.
module test_input_streamer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           cfg_addr_i,
    input  logic [15:0]           cfg_size_i,
    input  logic [15:0]           cfg_stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [15:0]           size_q;
    logic [15:0]           stride_q;
    logic [15:0]           issued;
    logic [15:0]           popped;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                  gnt;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  final_pop;
    logic [15:0]           size_n;
    logic [15:0]           issued_n;
    logic [15:0]           popped_n;
    logic [CW-1:0]         outstanding_n;
    logic [CW-1:0]         count_n;
    logic [CW:0]           credit_n;
    logic                  req_n;

    assign valid_o = (count != '0);
    assign data_o  = fifo_mem[rd_ptr];
    assign last_o  = valid_o && (popped == size_q - 16'd1);

    // The request flag is registered, so it is derived from next-cycle counter
    // values; without a grant the credit can only fall, so a raised request holds.
    always_comb begin
        gnt       = mem_req_o & mem_gnt_i;
        push      = mem_rvalid_i & (outstanding != '0);
        pop       = valid_o & ready_i;
        accept    = (state == IDLE) & start_i;
        final_pop = (state == RUN) & pop & ((popped + 16'd1) == size_q);

        state_n = state;
        if (accept && (cfg_size_i != '0)) begin
            state_n = RUN;
        end else if (final_pop) begin
            state_n = IDLE;
        end

        size_n   = accept ? cfg_size_i : size_q;
        issued_n = accept ? '0 : issued + {15'd0, gnt};
        popped_n = accept ? '0 : popped + {15'd0, pop};

        case ({gnt, push})
            2'b10:   outstanding_n = outstanding + CW'(1);
            2'b01:   outstanding_n = outstanding - CW'(1);
            default: outstanding_n = outstanding;
        endcase

        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase

        credit_n = {1'b0, outstanding_n} + {1'b0, count_n};
        req_n    = (state_n == RUN) && (issued_n < size_n) && (credit_n < DEPTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            size_q      <= '0;
            stride_q    <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
        end else begin
            state       <= state_n;
            size_q      <= size_n;
            issued      <= issued_n;
            popped      <= popped_n;
            outstanding <= outstanding_n;
            count       <= count_n;
            mem_req_o   <= req_n;
            busy_o      <= (state_n == RUN);
            done_o      <= (accept && (cfg_size_i == '0)) || final_pop;

            // Address accumulator: base on start, advanced by the stride per grant.
            if (accept) begin
                mem_addr_o <= cfg_addr_i;
                stride_q   <= cfg_stride_i;
            end else if (gnt) begin
                mem_addr_o <= mem_addr_o + {16'd0, stride_q};
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule
